// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline sequencer. Drives stage enables/flushes from
// load-use, taken-branch and data-memory stall terms. The dmem request FSM
// (IDLE/BUSY/ERR) issues dmem_req/dmem_we and latches a sticky timeout error.
// Ports: clk, rst (sync, active high); id_rs1/id_rs2/ex_rd, ex_mem_read,
// ex_branch, is_zero, mem_valid, mem_write, dmem_ack in; dmem_req, dmem_we,
// stage enables/flushes, pc_sel_branch, mem_err, stall_cycles out.
module pipe_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int REG_AW  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_branch,
   input  logic              is_zero,
   input  logic              mem_valid,
   input  logic              mem_write,
   input  logic              dmem_ack,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic              pc_en,
   output logic              if_id_en,
   output logic              id_ex_en,
   output logic              ex_mem_en,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              mem_wb_flush,
   output logic              pc_sel_branch,
   output logic              mem_err,
   output logic [31:0]       stall_cycles
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ERR  = 2'd2
   } state_t;

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  wait_q, wait_d;
   logic [31:0] stall_cnt;

   logic mem_stall;
   logic lu;
   logic br;

   assign lu = ex_mem_read && (ex_rd != '0) &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));
   assign br = ex_branch && is_zero;

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      mem_stall = 1'b0;
      unique case (state_q)
         IDLE: begin
            mem_stall = mem_valid;
            if (mem_valid)
               state_d = BUSY;
         end
         BUSY: begin
            mem_stall = !dmem_ack;
            // ack in the final BUSY cycle beats the timeout
            if (dmem_ack) begin
               state_d = IDLE;
               wait_d  = '0;
            end else if (wait_q == LAST) begin
               state_d = ERR;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         ERR: state_d = ERR;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      mem_wb_flush  = 1'b0;
      pc_sel_branch = 1'b0;
      if (rst || state_q == ERR) begin
         pc_en = 1'b0;
      end else if (mem_stall) begin
         // inputs stay frozen, so a pending branch resolves after release
         mem_wb_flush = 1'b1;
      end else if (br) begin
         pc_en         = 1'b1;
         if_id_en      = 1'b1;
         id_ex_en      = 1'b1;
         ex_mem_en     = 1'b1;
         pc_sel_branch = 1'b1;
         if_id_flush   = 1'b1;
         id_ex_flush   = 1'b1;
      end else if (lu) begin
         id_ex_en    = 1'b1;
         id_ex_flush = 1'b1;
         ex_mem_en   = 1'b1;
      end else begin
         pc_en     = 1'b1;
         if_id_en  = 1'b1;
         id_ex_en  = 1'b1;
         ex_mem_en = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wait_q    <= '0;
         dmem_req  <= 1'b0;
         dmem_we   <= 1'b0;
         mem_err   <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         dmem_req <= (state_d == BUSY);
         mem_err  <= (state_d == ERR);
         if (state_q == IDLE && mem_valid)
            dmem_we <= mem_write;
         if (state_q != ERR && (mem_stall || (lu && !br)))
            stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt;

endmodule
